queue_op_arbiter: RTL and testbench

Round-robin arbiter that shares the single operation port of the order queue (push/pop/remove/modify) between NUM_REQ requesters. Each requester uses a valid/ready handshake and gets exactly one tagged response per accepted operation. The arbiter keeps one operation in flight so the queue's registered status flags can be attributed to the correct operation. Pops on an empty queue are rejected locally and never reach the queue.

---
 rtl/queue_op_arbiter.sv | 177 +++++++++++++++++
 tb/tb_queue_op_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/queue_op_arbiter.sv
// Round-robin arbiter sharing the order queue's single operation port
// between NUM_REQ requesters. One operation is kept in flight so that the
// queue's registered error flags line up with the operation that caused them.
//
// state | meaning
// IDLE  | waiting for a request; grants the round-robin winner this cycle
// ISSUE | op_valid to the queue; capture pop data while it is valid
// RESP  | one-cycle response strobe; status taken from the queue's flags
module queue_op_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_SIZE = 64,
  parameter int FIFO_SIZE = 64,
  parameter int PTR_WIDTH = $clog2(FIFO_SIZE),
  parameter int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [2*NUM_REQ-1:0]           req_flag,
  input  logic [PTR_WIDTH*NUM_REQ-1:0]   req_index,
  input  logic [DATA_SIZE*NUM_REQ-1:0]   req_data,
  output logic [1:0]                     q_op_flag,
  output logic [PTR_WIDTH-1:0]           q_op_index,
  output logic [DATA_SIZE-1:0]           q_op_data,
  output logic                           q_op_valid,
  input  logic [DATA_SIZE-1:0]           q_pop_data,
  input  logic                           q_empty,
  input  logic                           q_error_reg,
  input  logic                           q_error_rem,
  input  logic                           q_error_time,
  output logic                           rsp_valid,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [1:0]                     rsp_flag,
  output logic [DATA_SIZE-1:0]           rsp_data,
  output logic [1:0]                     rsp_status
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  localparam logic [1:0] OP_PUSH   = 2'b00;
  localparam logic [1:0] OP_POP    = 2'b01;

  localparam logic [1:0] ST_OK       = 2'b00;
  localparam logic [1:0] ST_ERR_REG  = 2'b01;
  localparam logic [1:0] ST_ERR_REM  = 2'b10;
  localparam logic [1:0] ST_ERR_TIME = 2'b11;

  localparam logic [ID_WIDTH:0] NUM_REQ_W = (ID_WIDTH+1)'(NUM_REQ);

  state_t                  state_q;
  logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0]     id_q;
  logic [1:0]              flag_q;
  logic [PTR_WIDTH-1:0]    index_q;
  logic [DATA_SIZE-1:0]    data_q;
  logic [DATA_SIZE-1:0]    rdata_q;
  logic                    reject_q;
  logic                    q_op_valid_q;
  logic                    rsp_valid_q;

  logic [1:0]              flag_arr  [NUM_REQ];
  logic [PTR_WIDTH-1:0]    index_arr [NUM_REQ];
  logic [DATA_SIZE-1:0]    data_arr  [NUM_REQ];

  logic                    any_valid;
  logic                    grant;
  logic [ID_WIDTH-1:0]     winner;
  logic [ID_WIDTH:0]       cand;
  logic [1:0]              status;

  // Unpack the flat per-requester buses into indexable arrays
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      flag_arr[i]  = req_flag[2*i +: 2];
      index_arr[i] = req_index[PTR_WIDTH*i +: PTR_WIDTH];
      data_arr[i]  = req_data[DATA_SIZE*i +: DATA_SIZE];
    end
  end

  // Round-robin search: first valid requester at or after rr_ptr, wrapping
  always_comb begin
    any_valid = 1'b0;
    winner    = rr_ptr_q;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
      if (cand >= NUM_REQ_W) cand = cand - NUM_REQ_W;
      if (!any_valid && req_valid[cand[ID_WIDTH-1:0]]) begin
        any_valid = 1'b1;
        winner    = cand[ID_WIDTH-1:0];
      end
    end
    if ({1'b0, winner} == NUM_REQ_W - (ID_WIDTH+1)'(1)) rr_ptr_d = '0;
    else                                                 rr_ptr_d = winner + ID_WIDTH'(1);
  end

  // Grant is a same-cycle strobe; held low while reset is asserted
  always_comb begin
    grant     = (state_q == IDLE) && any_valid && !reset;
    req_ready = grant ? (NUM_REQ'(1) << winner) : '0;
  end

  // Sequencer: issue register, round-robin pointer and registered strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      id_q         <= '0;
      flag_q       <= '0;
      index_q      <= '0;
      data_q       <= '0;
      rdata_q      <= '0;
      reject_q     <= 1'b0;
      q_op_valid_q <= 1'b0;
      rsp_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            id_q     <= winner;
            flag_q   <= flag_arr[winner];
            index_q  <= index_arr[winner];
            data_q   <= data_arr[winner];
            rdata_q  <= '0;
            rr_ptr_q <= rr_ptr_d;
            if (flag_arr[winner] == OP_POP && q_empty) begin
              reject_q    <= 1'b1;
              rsp_valid_q <= 1'b1;
              state_q     <= RESP;
            end else begin
              reject_q     <= 1'b0;
              q_op_valid_q <= 1'b1;
              state_q      <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (flag_q == OP_POP) rdata_q <= q_pop_data;
          q_op_valid_q <= 1'b0;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Status comes from the queue's flags as they stand one clock after the op
  always_comb begin
    status = ST_OK;
    if (reject_q) begin
      status = ST_ERR_REG;
    end else begin
      case (flag_q)
        OP_PUSH: if (q_error_reg)  status = ST_ERR_REG;
        OP_POP:  if (q_error_time) status = ST_ERR_TIME;
        default: if (q_error_rem)  status = ST_ERR_REM;
      endcase
    end
  end

  assign q_op_flag  = flag_q;
  assign q_op_index = index_q;
  assign q_op_data  = data_q;
  assign q_op_valid = q_op_valid_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_flag   = flag_q;
  assign rsp_status = rsp_valid_q ? status : ST_OK;
  assign rsp_data   = (rsp_valid_q && flag_q == OP_POP && status == ST_OK) ? rdata_q : '0;

endmodule

// File: tb/tb_queue_op_arbiter.sv
// Bench for queue_op_arbiter: directed operations against a small behavioural
// order queue; expected responses go to a scoreboard checked by a monitor.
module tb_queue_op_arbiter;

  localparam int NR = 4;
  localparam int DW = 64;
  localparam int FS = 64;
  localparam int PW = 6;
  localparam int IW = 2;

  localparam logic [1:0] PUSH = 2'b00, POP = 2'b01, REMOVE = 2'b10, MODIFY = 2'b11;
  localparam logic [1:0] OK = 2'b00, E_REG = 2'b01, E_REM = 2'b10, E_TIME = 2'b11;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [2*NR-1:0]   req_flag;
  logic [PW*NR-1:0]  req_index;
  logic [DW*NR-1:0]  req_data;
  logic [1:0]        q_op_flag;
  logic [PW-1:0]     q_op_index;
  logic [DW-1:0]     q_op_data;
  logic              q_op_valid;
  logic [DW-1:0]     q_pop_data;
  logic              q_empty;
  logic              q_error_reg, q_error_rem, q_error_time;
  logic              rsp_valid;
  logic [IW-1:0]     rsp_id;
  logic [1:0]        rsp_flag;
  logic [DW-1:0]     rsp_data;
  logic [1:0]        rsp_status;

  logic [2:0]        force_err;   // {time, rem, reg} forced onto the queue flags

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [1:0]  id;
    logic [1:0]  flag;
    logic [63:0] data;
    logic [1:0]  st;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  queue_op_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DW), .FIFO_SIZE(FS)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_flag(req_flag),
    .req_index(req_index), .req_data(req_data),
    .q_op_flag(q_op_flag), .q_op_index(q_op_index), .q_op_data(q_op_data),
    .q_op_valid(q_op_valid), .q_pop_data(q_pop_data), .q_empty(q_empty),
    .q_error_reg(q_error_reg), .q_error_rem(q_error_rem), .q_error_time(q_error_time),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_flag(rsp_flag),
    .rsp_data(rsp_data), .rsp_status(rsp_status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // ---------------- behavioural order queue ----------------
  logic [DW-1:0] mem [FS];
  logic [FS-1:0] vld;
  logic [PW-1:0] head, tail, pop_slot, scan;
  int            cnt;
  logic          found;
  logic          m_err_reg, m_err_rem;

  always_comb begin
    found    = 1'b0;
    pop_slot = head;
    scan     = head;
    for (int k = 0; k < FS; k++) begin
      scan = head + PW'(k);
      if (!found && vld[scan]) begin
        found    = 1'b1;
        pop_slot = scan;
      end
    end
    q_pop_data = found ? mem[pop_slot] : '0;
  end

  assign q_empty      = (cnt == 0);
  assign q_error_reg  = m_err_reg | force_err[0];
  assign q_error_rem  = m_err_rem | force_err[1];
  assign q_error_time = force_err[2];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      vld <= '0; head <= '0; tail <= '0; cnt <= 0;
      m_err_reg <= 1'b0; m_err_rem <= 1'b0;
    end else if (q_op_valid) begin
      m_err_reg <= 1'b0;
      m_err_rem <= 1'b0;
      case (q_op_flag)
        PUSH: if (cnt == FS) m_err_reg <= 1'b1;
              else begin
                mem[tail] <= q_op_data; vld[tail] <= 1'b1;
                tail <= tail + 1'b1; cnt <= cnt + 1;
              end
        POP:  if (cnt == 0) m_err_reg <= 1'b1;
              else begin
                vld[pop_slot] <= 1'b0; head <= pop_slot + 1'b1; cnt <= cnt - 1;
              end
        REMOVE: if (!vld[q_op_index]) m_err_rem <= 1'b1;
                else begin vld[q_op_index] <= 1'b0; cnt <= cnt - 1; end
        default: if (!vld[q_op_index]) m_err_rem <= 1'b1;
                 else mem[q_op_index] <= q_op_data;
      endcase
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every response strobe must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && rsp_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_rsp actual id=%0d flag=%0d required no response", rsp_id, rsp_flag);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_id",     64'(rsp_id),     64'(mon_e.id));
        chk("rsp_flag",   64'(rsp_flag),   64'(mon_e.flag));
        chk("rsp_data",   rsp_data,        mon_e.data);
        chk("rsp_status", 64'(rsp_status), 64'(mon_e.st));
        chk("rsp_cycle",  64'(cyc),        64'(mon_e.cyc));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic op(input int id, input logic [1:0] flag, input logic [5:0] idx,
                    input logic [63:0] data, input logic [1:0] st,
                    input logic [63:0] rdata, input bit reject);
    int n;
    exp_t e;
    logic [3:0] onehot;
    @(posedge clk); #1;
    req_flag[2*id +: 2]   = flag;
    req_index[PW*id +: PW] = idx;
    req_data[DW*id +: DW] = data;
    req_valid[id]         = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    onehot = 4'b0001 << id;
    chk("grant", 64'(req_ready), 64'(onehot));
    e.id = 2'(id); e.flag = flag; e.data = rdata; e.st = st;
    e.cyc = cyc + (reject ? 1 : 2);
    exp_q.push_back(e);
    @(posedge clk); #1;
    req_valid[id] = 1'b0;
    @(negedge clk);
    chk("op_valid", 64'(q_op_valid), reject ? 64'd0 : 64'd1);
    if (!reject) begin
      chk("op_flag", 64'(q_op_flag), 64'(flag));
      if (flag == PUSH || flag == MODIFY)   chk("op_data", q_op_data, data);
      if (flag == REMOVE || flag == MODIFY) chk("op_index", 64'(q_op_index), 64'(idx));
    end
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req_ready"},  64'(req_ready),  64'd0);
    chk({tag, "_q_op_valid"}, 64'(q_op_valid), 64'd0);
    chk({tag, "_rsp_valid"},  64'(rsp_valid),  64'd0);
    chk({tag, "_rsp_id"},     64'(rsp_id),     64'd0);
    chk({tag, "_rsp_flag"},   64'(rsp_flag),   64'd0);
    chk({tag, "_rsp_data"},   rsp_data,        64'd0);
    chk({tag, "_rsp_status"}, 64'(rsp_status), 64'd0);
    chk({tag, "_q_op_flag"},  64'(q_op_flag),  64'd0);
    chk({tag, "_q_op_index"}, 64'(q_op_index), 64'd0);
    chk({tag, "_q_op_data"},  q_op_data,       64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int last_cyc;
    logic [3:0] onehot;
    exp_t e;

    reset = 1'b1; req_valid = '0; req_flag = '0; req_index = '0; req_data = '0;
    force_err = 3'b000;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs("post_rst");

    // basic push, pop, reject on empty, push/pop round trip
    op(2, PUSH,   6'd0, 64'hAB, OK,    64'h0,  1'b0);
    op(0, POP,    6'd0, 64'h0,  OK,    64'hAB, 1'b0);
    op(1, POP,    6'd0, 64'h0,  E_REG, 64'h0,  1'b1);
    op(3, PUSH,   6'd0, 64'h11, OK,    64'h0,  1'b0);
    op(3, POP,    6'd0, 64'h0,  OK,    64'h11, 1'b0);

    // invalid remove; modify a live slot then pop it; remove a live slot
    op(0, REMOVE, 6'd5, 64'h0,  E_REM, 64'h0,  1'b0);
    op(1, PUSH,   6'd0, 64'h33, OK,    64'h0,  1'b0);
    op(2, PUSH,   6'd0, 64'h44, OK,    64'h0,  1'b0);
    op(0, MODIFY, 6'd2, 64'h22, OK,    64'h0,  1'b0);
    op(1, POP,    6'd0, 64'h0,  OK,    64'h22, 1'b0);
    op(3, REMOVE, 6'd3, 64'h0,  OK,    64'h0,  1'b0);

    // status selection: each opcode looks only at its own error flag
    force_err = 3'b100;
    op(2, PUSH,   6'd0, 64'h55, OK,     64'h0, 1'b0);
    op(0, POP,    6'd0, 64'h0,  E_TIME, 64'h0, 1'b0);
    force_err = 3'b011;
    op(1, PUSH,   6'd0, 64'h66, E_REG,  64'h0, 1'b0);
    force_err = 3'b010;
    op(3, PUSH,   6'd0, 64'h77, OK,     64'h0, 1'b0);
    force_err = 3'b000;
    op(2, MODIFY, 6'd5, 64'h88, OK,     64'h0, 1'b0);
    op(0, POP,    6'd0, 64'h0,  OK,     64'h88, 1'b0);

    // reset while an operation is in ISSUE: no response may follow
    @(posedge clk); #1;
    req_flag[2*1 +: 2] = PUSH;
    req_data[DW*1 +: DW] = 64'h99;
    req_valid[1] = 1'b1;
    n = 0;
    @(negedge clk);
    while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
    chk("abort_grant", 64'(req_ready), 64'(4'b0010));
    @(posedge clk); #1;
    chk("abort_issue", 64'(q_op_valid), 64'd1);
    reset = 1'b1;
    for (int i = 0; i < NR; i++) begin
      req_flag[2*i +: 2]   = PUSH;
      req_data[DW*i +: DW] = 64'h100 + 64'(i);
    end
    req_valid = 4'hF;
    @(negedge clk);
    chk_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // all requesters asserted: grants 0,1,2,3,0 three cycles apart
    last_cyc = 0;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      @(negedge clk);
      while (req_ready == '0 && n < 20) begin @(negedge clk); n++; end
      onehot = 4'b0001 << (g % NR);
      chk("rr_grant", 64'(req_ready), 64'(onehot));
      if (g > 0) chk("rr_spacing", 64'(cyc - last_cyc), 64'd3);
      last_cyc = cyc;
      e.id = 2'(g % NR); e.flag = PUSH; e.data = 64'h0; e.st = OK; e.cyc = cyc + 2;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = '0;

    repeat (6) @(negedge clk);
    chk("sb_drain", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
